// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM state codes, command constants and
// the odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

  typedef logic [3:0] ps2_tx_state_t;

  localparam ps2_tx_state_t ST_IDLE       = 4'd0;
  localparam ps2_tx_state_t ST_INHIBIT    = 4'd1;
  localparam ps2_tx_state_t ST_RTS        = 4'd2;
  localparam ps2_tx_state_t ST_WAIT_START = 4'd3;
  localparam ps2_tx_state_t ST_DATA       = 4'd4;
  localparam ps2_tx_state_t ST_PARITY     = 4'd5;
  localparam ps2_tx_state_t ST_STOP       = 4'd6;
  localparam ps2_tx_state_t ST_ACK        = 4'd7;
  localparam ps2_tx_state_t ST_WAIT_IDLE  = 4'd8;
  localparam ps2_tx_state_t ST_FAIL_TO    = 4'd9;
  localparam ps2_tx_state_t ST_FAIL_NACK  = 4'd10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic       error_no_ack;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, command_was_sent, error_communication_timed_out, error_no_ack
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, command_was_sent, error_communication_timed_out, error_no_ack
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for PS2_CLK/PS2_DAT plus PS2_CLK falling-edge detect.
// Flops reset to 1 (idle bus) so leaving reset never fakes a falling edge.
module ps2_line_sync (
  input  logic clk,
  input  logic srst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       clk_prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg     <= 2'b11;
      sync_reg     <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      meta_reg     <= {ps2_dat_in, ps2_clk_in};
      sync_reg     <= meta_reg;
      clk_prev_reg <= sync_reg[0];
    end
  end

  assign clk_sync = sync_reg[0];
  assign dat_sync = sync_reg[1];
  assign clk_fall = clk_prev_reg & ~sync_reg[0];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data bits,
// parity and stop on device clocks, then check ACK. Define PS2_HOST_TX_RETRY_EN to retry failures.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
`ifdef PS2_HOST_TX_RETRY_EN
  , parameter int MAX_RETRIES        = 2
`endif
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave cmd,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DAT
);
  localparam int CNT_MAX = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES)
                         ? ((START_TIMEOUT_CYCLES > INHIBIT_CYCLES) ? START_TIMEOUT_CYCLES : INHIBIT_CYCLES)
                         : ((XFER_TIMEOUT_CYCLES > INHIBIT_CYCLES) ? XFER_TIMEOUT_CYCLES : INHIBIT_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  ps2_tx_state_t    state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] xfer_cnt_reg;
  logic [8:0]       shift_reg;
  logic [2:0]       bit_idx_reg;
  logic             ack_bit_reg;
  logic             done_reg;
  logic             err_to_reg;
  logic             err_nack_reg;
  logic             clk_sync;
  logic             dat_sync;
  logic             clk_fall;
  logic             in_xfer;
  logic             xfer_timeout;
  logic             retry_ok;
  logic             clk_low;
  logic             dat_low;

  ps2_line_sync u_sync (
    .clk        (CLOCK_50),
    .srst       (reset),
    .ps2_clk_in (PS2_CLK),
    .ps2_dat_in (PS2_DAT),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  assign in_xfer = (state_reg == ST_DATA) || (state_reg == ST_PARITY) || (state_reg == ST_STOP)
                || (state_reg == ST_ACK) || (state_reg == ST_WAIT_IDLE);
  assign xfer_timeout = (xfer_cnt_reg == CNT_W'(XFER_TIMEOUT_CYCLES - 1));

  // Transfer watchdog starts at zero on the first device falling edge (entry to DATA).
  always_ff @(posedge CLOCK_50) begin
    if (reset || !in_xfer) xfer_cnt_reg <= '0;
    else                   xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
  end

`ifdef PS2_HOST_TX_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
  logic [RETRY_W-1:0] retry_cnt_reg;
  logic               in_fail;

  assign in_fail  = (state_reg == ST_FAIL_TO) || (state_reg == ST_FAIL_NACK);
  assign retry_ok = in_fail && (retry_cnt_reg < RETRY_W'(MAX_RETRIES));

  // Cleared whenever the FSM rests in IDLE: after success, final failure or reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset || state_reg == ST_IDLE) retry_cnt_reg <= '0;
    else if (retry_ok)                 retry_cnt_reg <= retry_cnt_reg + 1'b1;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      ack_bit_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_to_reg   <= 1'b0;
      err_nack_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      err_to_reg   <= 1'b0;
      err_nack_reg <= 1'b0;
      if (in_xfer && xfer_timeout) begin
        state_reg <= ST_FAIL_TO;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmd.cmd_valid) begin
              shift_reg <= {odd_parity(cmd.cmd_data), cmd.cmd_data};
              cnt_reg   <= '0;
              state_reg <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_RTS;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_RTS: begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (clk_fall) begin
              bit_idx_reg <= '0;
              state_reg   <= ST_DATA;
            end else if (cnt_reg == CNT_W'(START_TIMEOUT_CYCLES - 1)) begin
              state_reg <= ST_FAIL_TO;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_DATA: begin
            if (clk_fall) begin
              if (bit_idx_reg == 3'd7) state_reg <= ST_PARITY;
              else                     bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
          ST_PARITY: if (clk_fall) state_reg <= ST_STOP;
          ST_STOP: begin
            // The device drives its ACK before this edge; capture it here.
            if (clk_fall) begin
              ack_bit_reg <= dat_sync;
              state_reg   <= ST_ACK;
            end
          end
          ST_ACK:       state_reg <= ack_bit_reg ? ST_FAIL_NACK : ST_WAIT_IDLE;
          ST_WAIT_IDLE: begin
            if (clk_sync && dat_sync) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
          ST_FAIL_TO, ST_FAIL_NACK: begin
            if (retry_ok) begin
              cnt_reg   <= '0;
              state_reg <= ST_INHIBIT;
            end else begin
              err_to_reg   <= (state_reg == ST_FAIL_TO);
              err_nack_reg <= (state_reg == ST_FAIL_NACK);
              state_reg    <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Open-drain: a 1 bit is sent by releasing the line to the pull-up.
  always_comb begin
    clk_low = 1'b0;
    dat_low = 1'b0;
    case (state_reg)
      ST_INHIBIT:    clk_low = 1'b1;
      ST_RTS:        begin clk_low = 1'b1; dat_low = 1'b1; end
      ST_WAIT_START: dat_low = 1'b1;
      ST_DATA:       dat_low = ~shift_reg[bit_idx_reg];
      ST_PARITY:     dat_low = ~shift_reg[8];
      default:       ;
    endcase
  end

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign cmd.cmd_ready                     = (state_reg == ST_IDLE);
  assign cmd.busy                          = (state_reg != ST_IDLE);
  assign cmd.command_was_sent              = done_reg;
  assign cmd.error_communication_timed_out = err_to_reg;
  assign cmd.error_no_ack                  = err_nack_reg;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- It is the counterpart of the existing PS/2 receive path and shares the PS2_CLK/PS2_DAT open-drain lines with it.
- Sequence: inhibits the bus, issues the request-to-send, shifts data/parity/stop on device-generated clocks, then checks the device ACK.
- Reports completion or failure via single-cycle pulses, using the same names as the receive controller's status outputs.

Parameters:
INHIBIT_CYCLES, 6000, cycles PS2_CLK held low before request-to-send (120 us at 50 MHz)
START_TIMEOUT_CYCLES, 750000, max cycles from clock release to first device falling edge (15 ms)
XFER_TIMEOUT_CYCLES, 100000, max cycles from first falling edge to ACK sampled (2 ms)
MAX_RETRIES, 2, extra attempts after a failure (used only with PS2_HOST_TX_RETRY_EN)

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_data  input  8  command byte to send
cmd_valid  input  1  request; accepted when cmd_valid && cmd_ready
cmd_ready  output  1  high only in IDLE
PS2_CLK  inout  1  open-drain; drives 0 or Z, never 1
PS2_DAT  inout  1  open-drain; drives 0 or Z, never 1
command_was_sent  output  1  1-cycle pulse: byte ACKed, bus idle again
error_communication_timed_out  output  1  1-cycle pulse: start or transfer timeout
error_no_ack  output  1  1-cycle pulse: ACK bit sampled high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state IDLE; cmd_ready=1, busy=0; all pulses 0.
  - Both lines released (Z); counters and shift register cleared.
- Reset mid-transfer: lines released on the next edge; no pulse emitted.
- Input synchronisation:
  - PS2_CLK and PS2_DAT pass through 2-flop synchronisers.
  - falling edge = previous synced clock 1, current 0.
- Accept: on cmd_valid && cmd_ready, latch {odd parity, cmd_data}. Parity = ~^cmd_data. cmd_valid while busy is ignored.
- States:
  - IDLE: lines Z. Accept -> INHIBIT, counter cleared.
  - INHIBIT: drive PS2_CLK=0, PS2_DAT=Z. After INHIBIT_CYCLES -> RTS.
  - RTS: one cycle driving PS2_CLK=0 and PS2_DAT=0 -> WAIT_START.
  - WAIT_START: PS2_CLK=Z, PS2_DAT=0 (start bit). First falling edge -> DATA, drive bit0. START_TIMEOUT_CYCLES without an edge -> FAIL_TO.
  - DATA: on each falling edge, advance bit index 0..7, updating PS2_DAT to the next bit (LSB first; 1=Z, 0=drive 0). Falling edge after bit7 -> PARITY.
  - PARITY: after 1 edge -> STOP, data released (Z).
  - STOP: on next falling edge -> ACK.
  - ACK: sample synced PS2_DAT on that falling edge. 0 -> WAIT_IDLE; 1 -> FAIL_NACK.
  - WAIT_IDLE: wait until both synced lines are 1, then pulse command_was_sent -> IDLE.
- Transfer timeout: counter runs from the first falling edge; reaching XFER_TIMEOUT_CYCLES in DATA, PARITY, STOP, ACK or WAIT_IDLE -> FAIL_TO.
- FAIL_TO / FAIL_NACK: release lines, pulse the matching error for 1 cycle -> IDLE.
- Total falling edges consumed per byte: 11 (1 start + 8 data + parity + stop/ACK).
- Latency: cmd accept to INHIBIT is 1 cycle. Pulses are registered and go high 1 cycle after the deciding condition.

Optional Feature:
PS2_HOST_TX_RETRY_EN
- Defined:
  - FAIL_TO or FAIL_NACK reloads the latched byte and returns to INHIBIT, up to MAX_RETRIES times.
  - Error pulse is emitted only after the final attempt fails.
  - busy stays high across retries.
  - The retry counter clears on success or reset.
- Undefined: no retry; the first failure pulses its error and returns to IDLE.

Decomposition:
- Shared package ps2_pkg: state enum, PS2 command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA), and an odd-parity function.
- One sub-module, ps2_line_sync: 2-flop synchroniser plus falling-edge detector for PS2_CLK, with synced PS2_DAT. It is shared with the receive path.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs -> PS2_CLK low ≥6000 cycles; bits observed 0,1,0,1,1,0,1,1,1 (parity 1), stop 1; command_was_sent pulses once; cmd_ready returns to 1.
- Send 0x01 -> parity bit 0 observed; send 0xFF -> parity bit 1; both complete with command_was_sent.
- Device never clocks -> error_communication_timed_out pulses at START_TIMEOUT_CYCLES (+1) after clock release; both lines Z afterward.
- Device leaves DAT high at ACK -> error_no_ack pulses; with PS2_HOST_TX_RETRY_EN and MAX_RETRIES=2 -> 3 inhibit phases seen before the single error pulse.
- Assert reset during DATA bit 4 -> next cycle lines Z, state IDLE, no pulses; a new 0xED then transfers correctly.
- Pulse cmd_valid with 0x55 while busy sending 0xED -> ignored; exactly one byte (0xED) transmitted.
